alu_result_capture: RTL and testbench

Receives the 7-bit result and 1-bit flag stream produced by the ALU/FSM top level and buffers it for a downstream reader. Capture is armed by a command, runs for a programmable number of samples, then stops. Captured words go into a small FIFO drained over a valid/ready interface. A saturating count of flagged results and a sticky overflow indicator are kept alongside. The block sits beside the ALU/FSM top and turns its free-running outputs into a flow-controlled stream.

---
 rtl/alu_result_capture_pkg.sv | 19 +
 rtl/alu_result_capture_fifo.sv | 80 ++++++++
 rtl/alu_result_capture.sv | 123 ++++++++++++
 tb/tb_alu_result_capture.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_capture_pkg.sv
// Shared types and word layout for the ALU result capture block.
package alu_result_capture_pkg;

  localparam int RESULT_W = 7;
  localparam int WORD_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } cap_state_e;

  // Flag occupies the MSB so a reader sees {flag, result}.
  function automatic logic [WORD_W-1:0] pack_word(input logic flag,
                                                  input logic [RESULT_W-1:0] result);
    return {flag, result};
  endfunction

endpackage

// File: rtl/alu_result_capture_fifo.sv
// Synchronous FIFO with a registered head word presented on a valid/ready read port.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             do_pop_s;
  logic             do_push_s;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // A pop on a full FIFO frees the slot the push lands in, so the push is accepted.
  always_comb begin
    do_pop_s  = valid_q && out_ready;
    do_push_s = push && (!full || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    valid_d = (wr_ptr_d != rd_ptr_d);
    // Head is bypassed from the write port when the new word becomes the only entry.
    if (do_push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data;
    end else if (valid_d) begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/alu_result_capture.sv
// Arms on command, captures CAP_LEN ALU samples into a FIFO, and keeps flag and overflow status.
module alu_result_capture
  import alu_result_capture_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CAP_LEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                in_valid,
  input  logic [RESULT_W-1:0] in_result,
  input  logic                in_flag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                busy,
  output logic                done,
  output logic [7:0]          flag_count,
  output logic                overflow
);

  localparam logic [7:0] CAP_LEN_W = 8'(CAP_LEN);

  cap_state_e  state_q, state_d;
  logic [7:0]  sample_cnt_q, sample_cnt_d;
  logic [7:0]  flag_count_q, flag_count_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        push_s;
  logic        accept_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    flag_count_d = flag_count_q;
    overflow_d   = overflow_q;
    push_s       = 1'b0;
    // A same-cycle pop makes room even when the FIFO reads full.
    accept_s     = !fifo_full_s || (!fifo_empty_s && out_ready);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d      = ST_ARMED;
          sample_cnt_d = 8'd0;
          flag_count_d = 8'd0;
          overflow_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ARMED: begin
        if (in_valid) begin
          sample_cnt_d = sample_cnt_q + 8'd1;
          if (accept_s) begin
            push_s = 1'b1;
            if (in_flag && (flag_count_q != 8'hFF)) begin
              flag_count_d = flag_count_q + 8'd1;
            end else begin
              flag_count_d = flag_count_q;
            end
          end else begin
            overflow_d = 1'b1;
          end
          if ((sample_cnt_q + 8'd1) == CAP_LEN_W) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_ARMED);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= 8'd0;
      flag_count_q <= 8'd0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      flag_count_q <= flag_count_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (pack_word(in_flag, in_result)),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign flag_count = flag_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_alu_result_capture.sv
// Scoreboard bench: three capture instances share the sample bus; each has its own arm/ready and monitor.
module tb_alu_result_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [6:0] in_result;
  logic       in_flag;
  logic       arm_a, arm_b, arm_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       ov_a, ov_b, ov_c;
  logic [7:0] od_a, od_b, od_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] fc_a, fc_b, fc_c;
  logic       ovf_a, ovf_b, ovf_c;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pops_b    = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  always #5 clk = ~clk;

  alu_result_capture #(.DEPTH(8), .CAP_LEN(4)) u_a (
    .clk(clk), .reset(reset), .arm(arm_a), .in_valid(in_valid), .in_result(in_result),
    .in_flag(in_flag), .out_valid(ov_a), .out_ready(rdy_a), .out_data(od_a),
    .busy(busy_a), .done(done_a), .flag_count(fc_a), .overflow(ovf_a));

  alu_result_capture #(.DEPTH(8), .CAP_LEN(10)) u_b (
    .clk(clk), .reset(reset), .arm(arm_b), .in_valid(in_valid), .in_result(in_result),
    .in_flag(in_flag), .out_valid(ov_b), .out_ready(rdy_b), .out_data(od_b),
    .busy(busy_b), .done(done_b), .flag_count(fc_b), .overflow(ovf_b));

  alu_result_capture #(.DEPTH(4), .CAP_LEN(200)) u_c (
    .clk(clk), .reset(reset), .arm(arm_c), .in_valid(in_valid), .in_result(in_result),
    .in_flag(in_flag), .out_valid(ov_c), .out_ready(rdy_c), .out_data(od_c),
    .busy(busy_c), .done(done_c), .flag_count(fc_c), .overflow(ovf_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic v, input logic [6:0] r, input logic f);
    in_valid  = v;
    in_result = r;
    in_flag   = f;
    cyc();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Monitors: compare every accepted head word and check the head holds during stalls.
  logic stall_a, stall_b, stall_c;
  logic [7:0] held_a, held_b, held_c;

  always @(negedge clk) begin
    if (reset) begin
      stall_a <= 1'b0;
    end else begin
      if (stall_a) begin
        chk("stall_valid_a", ov_a, 1'b1);
        chk("stall_data_a", od_a, held_a);
      end
      if (ov_a && rdy_a) begin
        if (q_a.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_pop_a: got %02h expected no word", od_a);
        end else chk("pop_a", od_a, q_a.pop_front());
      end
      stall_a <= ov_a && !rdy_a;
      held_a  <= od_a;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stall_b <= 1'b0;
    end else begin
      if (stall_b) begin
        chk("stall_valid_b", ov_b, 1'b1);
        chk("stall_data_b", od_b, held_b);
      end
      if (ov_b && rdy_b) begin
        pops_b++;
        if (q_b.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_pop_b: got %02h expected no word", od_b);
        end else chk("pop_b", od_b, q_b.pop_front());
      end
      stall_b <= ov_b && !rdy_b;
      held_b  <= od_b;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stall_c <= 1'b0;
    end else begin
      if (stall_c) begin
        chk("stall_valid_c", ov_c, 1'b1);
        chk("stall_data_c", od_c, held_c);
      end
      if (ov_c && rdy_c) begin
        if (q_c.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_pop_c: got %02h expected no word", od_c);
        end else chk("pop_c", od_c, q_c.pop_front());
      end
      stall_c <= ov_c && !rdy_c;
      held_c  <= od_c;
    end
  end

  logic [6:0] t1_r [4] = '{7'h05, 7'h7F, 7'h00, 7'h2A};
  logic       t1_f [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] t1_w [4] = '{8'h05, 8'hFF, 8'h80, 8'h2A};

  initial begin
    int   base;
    int   occ;
    int   n;
    logic drop;
    logic v, rdy, pop, ok, f;
    logic [6:0] r;

    reset = 1'b1; in_valid = 1'b0; in_result = 7'd0; in_flag = 1'b0;
    arm_a = 1'b0; arm_b = 1'b0; arm_c = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    repeat (2) cyc();
    chk("rst_out_valid", ov_a, 1'b0);
    chk("rst_out_data", od_a, 8'h00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_flag_count", fc_a, 8'h00);
    chk("rst_overflow", ovf_a, 1'b0);
    reset = 1'b0;
    cyc();

    // Samples while IDLE are ignored.
    for (int i = 0; i < 3; i++) sample(1'b1, 7'h11, 1'b1);
    idle(1);
    chk("idle_empty_a", ov_a, 1'b0);
    chk("idle_empty_b", ov_b, 1'b0);
    chk("idle_flag_count", fc_a, 8'h00);

    // Basic capture of four samples with the reader always ready.
    arm_a = 1'b1; cyc(); arm_a = 1'b0;
    chk("arm_busy", busy_a, 1'b1);
    rdy_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(t1_w[i]);
      sample(1'b1, t1_r[i], t1_f[i]);
      if (i == 0) chk("first_word_valid", ov_a, 1'b1);
      if (i < 3) chk("done_early_a", done_a, 1'b0);
    end
    chk("t1_done", done_a, 1'b1);
    chk("t1_busy_fall", busy_a, 1'b0);
    chk("t1_flag_count", fc_a, 8'd2);
    chk("t1_overflow", ovf_a, 1'b0);
    idle(3);
    chk("t1_all_read", q_a.size(), 32'd0);

    // Samples while DONE are ignored.
    for (int i = 0; i < 3; i++) sample(1'b1, 7'h33, 1'b1);
    idle(1);
    chk("done_ignore_empty", ov_a, 1'b0);
    chk("done_ignore_flags", fc_a, 8'd2);
    chk("done_stays", done_a, 1'b1);

    // Overflow: ten samples into an eight-deep FIFO with no reader.
    arm_b = 1'b1; cyc(); arm_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      r = 7'(i * 3 + 1);
      f = 1'(i % 2);
      if (i < 8) q_b.push_back({f, r});
      sample(1'b1, r, f);
      if (i == 7) chk("ovf_before_9th", ovf_b, 1'b0);
      if (i == 8) begin
        chk("ovf_after_9th", ovf_b, 1'b1);
        chk("busy_after_9th", busy_b, 1'b1);
      end
    end
    chk("t2_done", done_b, 1'b1);
    chk("t2_flag_count", fc_b, 8'd4);
    base = pops_b;
    in_valid = 1'b0; rdy_b = 1'b1;
    idle(12);
    chk("t2_drain_count", pops_b - base, 32'd8);
    chk("t2_drain_empty", ov_b, 1'b0);
    rdy_b = 1'b0;

    // Re-arm from DONE clears status; then push+pop while full.
    arm_b = 1'b1; cyc(); arm_b = 1'b0;
    chk("rearm_overflow", ovf_b, 1'b0);
    chk("rearm_flag_count", fc_b, 8'd0);
    chk("rearm_busy", busy_b, 1'b1);
    for (int i = 0; i < 10; i++) begin
      r = 7'(7'h40 + i);
      q_b.push_back({1'b0, r});
      rdy_b = (i >= 8);
      sample(1'b1, r, 1'b0);
    end
    in_valid = 1'b0; rdy_b = 1'b0;
    chk("full_pp_overflow", ovf_b, 1'b0);
    chk("full_pp_done", done_b, 1'b1);
    base = pops_b;
    rdy_b = 1'b1;
    idle(12);
    chk("full_pp_count", pops_b - base, 32'd8);
    chk("full_pp_all_read", q_b.size(), 32'd0);
    rdy_b = 1'b0;

    // Random reader stalls against a four-deep FIFO, occupancy tracked by a model.
    arm_c = 1'b1; cyc(); arm_c = 1'b0;
    occ = 0; n = 0; drop = 1'b0;
    while (n < 200) begin
      v   = ($urandom_range(0, 7) != 0);
      rdy = 1'($urandom_range(0, 1));
      r   = 7'($urandom);
      f   = 1'($urandom);
      pop = (occ > 0) && rdy;
      ok  = (occ < 4) || pop;
      if (v) begin
        n++;
        if (ok) q_c.push_back({f, r});
        else drop = 1'b1;
      end
      occ = occ - int'(pop) + int'(v && ok);
      rdy_c = rdy;
      sample(v, r, f);
    end
    chk("rand_done", done_c, 1'b1);
    chk("rand_overflow", ovf_c, drop);
    in_valid = 1'b0; rdy_c = 1'b1;
    idle(8);
    chk("rand_all_read", q_c.size(), 32'd0);
    rdy_c = 1'b0;

    // Asynchronous reset in the middle of a capture.
    arm_a = 1'b1; cyc(); arm_a = 1'b0;
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q_a.push_back(t1_w[i]);
      sample(1'b1, t1_r[i], t1_f[i]);
    end
    in_valid = 1'b0;
    chk("pre_rst_flags", fc_a, 8'd2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", ov_a, 1'b0);
    chk("mid_rst_out_data", od_a, 8'h00);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_done", done_a, 1'b0);
    chk("mid_rst_flag_count", fc_a, 8'h00);
    chk("mid_rst_overflow", ovf_a, 1'b0);
    q_a.delete(); q_b.delete(); q_c.delete();
    cyc();
    reset = 1'b0;
    cyc();
    arm_a = 1'b1; cyc(); arm_a = 1'b0;
    rdy_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(t1_w[i]);
      sample(1'b1, t1_r[i], t1_f[i]);
      if (i == 2) chk("post_rst_not_done", done_a, 1'b0);
    end
    chk("post_rst_done", done_a, 1'b1);
    chk("post_rst_flags", fc_a, 8'd2);
    idle(3);
    chk("post_rst_all_read", q_a.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
